// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-ported memory between fetch and load/store requesters.
// Optional performance counters are enabled by defining MEM_ARB_PERF_EN.
module mem_arbiter #(
    parameter int unsigned ADDR_W          = 32,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_ack,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    input  logic [DATA_W/8-1:0] d_be,
    output logic [DATA_W-1:0]   d_rdata,
    output logic                d_ack,
    output logic                mem_req,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_be,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                busy
`ifdef MEM_ARB_PERF_EN
    ,
    output logic [31:0]         perf_if_grants,
    output logic [31:0]         perf_d_grants,
    output logic [31:0]         perf_conflicts
`endif
);

    localparam int unsigned BE_W      = DATA_W / 8;
    localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_D, RESP} state_t;

    state_t              state_q, state_d;
    logic [3:0]          streak_q, streak_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
    logic                if_ack_q, if_ack_d;
    logic                d_ack_q, d_ack_d;
    logic                grant_if, grant_d;

    always_comb begin
        state_d     = state_q;
        streak_d    = streak_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        if_ack_d    = 1'b0;
        d_ack_d     = 1'b0;
        grant_if    = 1'b0;
        grant_d     = 1'b0;
        case (state_q)
            IDLE: begin
                // Data wins unless it has already taken STREAK_MAX grants past a waiting fetch.
                if (d_req && (!if_req || streak_q != STREAK_MAX)) begin
                    grant_d     = 1'b1;
                    state_d     = BUSY_D;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                    if (!if_req)
                        streak_d = '0;
                    else if (streak_q != STREAK_MAX)
                        streak_d = streak_q + 4'd1;
                end else if (if_req) begin
                    grant_if    = 1'b1;
                    state_d     = BUSY_IF;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    mem_be_d    = '1;
                    streak_d    = '0;
                end
            end
            BUSY_IF: begin
                if (mem_ready) begin
                    if_rdata_d = mem_rdata;
                    if_ack_d   = 1'b1;
                    mem_req_d  = 1'b0;
                    mem_we_d   = 1'b0;
                    state_d    = RESP;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    if (!mem_we_q)
                        d_rdata_d = mem_rdata;
                    d_ack_d   = 1'b1;
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            streak_q    <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            streak_q    <= streak_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            if_ack_q    <= if_ack_d;
            d_ack_q     <= d_ack_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_be    = mem_be_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_ack    = if_ack_q;
    assign d_ack     = d_ack_q;
    assign busy      = (state_q != IDLE);

`ifdef MEM_ARB_PERF_EN
    logic [31:0] perf_if_q, perf_if_d;
    logic [31:0] perf_d_q, perf_d_d;
    logic [31:0] perf_cf_q, perf_cf_d;
    logic        if_wait, d_wait;

    always_comb begin
        // A requester is served while its transaction is in flight or being acknowledged.
        if_wait   = if_req && !grant_if && (state_q != BUSY_IF) && !(state_q == RESP && if_ack_q);
        d_wait    = d_req && !grant_d && (state_q != BUSY_D) && !(state_q == RESP && d_ack_q);
        perf_if_d = perf_if_q + {31'd0, grant_if};
        perf_d_d  = perf_d_q + {31'd0, grant_d};
        perf_cf_d = perf_cf_q + {31'd0, (if_wait || d_wait)};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_if_q <= '0;
            perf_d_q  <= '0;
            perf_cf_q <= '0;
        end else begin
            perf_if_q <= perf_if_d;
            perf_d_q  <= perf_d_d;
            perf_cf_q <= perf_cf_d;
        end
    end

    assign perf_if_grants = perf_if_q;
    assign perf_d_grants  = perf_d_q;
    assign perf_conflicts = perf_cf_q;
`endif

endmodule
